anc_tap_buffer: RTL and testbench

- Reference-sample delay line directly downstream of the ANC frame controller.
- A rising edge of RAMDataEN writes the current deserialized sample into a circular buffer of the TAPS most recent samples.
- A rising edge of FilterEN streams all TAPS samples, newest first, one per clock, to the filter MAC stage.
- Writes that arrive during a stream are deferred, so each stream is a consistent snapshot of the buffer.

---
 rtl/anc_tap_buffer.sv | 224 ++++++++++++++++++++++
 tb/tb_anc_tap_buffer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anc_tap_buffer.sv
// anc_tap_buffer: reference-sample delay line feeding the ANC filter MAC.
// Keeps the TAPS most recent samples in a circular buffer and streams a
// consistent newest-first snapshot on each FilterEN rising edge. Writes that
// land during a stream are held in a one-deep pending register.
module anc_tap_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAPS   = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              Clk_100M,
    input  logic              Reset,
    input  logic              RAMDataEN,
    input  logic [DATA_W-1:0] SampleIn,
    input  logic              FilterEN,
    output logic [DATA_W-1:0] TapData,
    output logic [ADDR_W-1:0] TapIndex,
    output logic              TapValid,
    output logic              TapFirst,
    output logic              TapLast,
    output logic              Busy,
    output logic              WrOverrun,
    output logic              FiltOverlap
);

    localparam int unsigned       FILL_W   = ADDR_W + 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TAPS);
    localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(TAPS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } streamState_e;

    streamState_e state;
    streamState_e nextState;

    logic              ramDataEnD;
    logic              filterEnD;
    logic              wrEdge;
    logic              fltEdge;

    logic [DATA_W-1:0] mem [TAPS];
    logic [ADDR_W-1:0] wrPtr;
    logic [FILL_W-1:0] fillCnt;
    logic [FILL_W-1:0] fillNext;

    logic              pendValid;
    logic [DATA_W-1:0] pendData;

    logic [ADDR_W-1:0] tapK;
    logic [ADDR_W-1:0] baseAddr;
    logic [FILL_W-1:0] fillSnap;
    logic [ADDR_W-1:0] readAddr;
    logic              readHit;

    logic              commitPend;
    logic              directWr;
    logic              doWrite;
    logic [DATA_W-1:0] wrData;
    logic              deferWr;
    logic              overrunSet;
    logic              overlapSet;
    logic              startStream;
    logic              lastRead;

    assign wrEdge   = RAMDataEN & ~ramDataEnD;
    assign fltEdge  = FilterEN & ~filterEnD;
    assign doWrite  = commitPend | directWr;
    assign wrData   = commitPend ? pendData : SampleIn;
    assign fillNext = (fillCnt == FILL_MAX) ? fillCnt : fillCnt + FILL_W'(1);
    assign readAddr = baseAddr - tapK;
    assign readHit  = ({1'b0, tapK} < fillSnap);

    // Edge-detect history; reset high so levels already asserted are not edges
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            ramDataEnD <= 1'b1;
            filterEnD  <= 1'b1;
        end else begin
            ramDataEnD <= RAMDataEN;
            filterEnD  <= FilterEN;
        end
    end

    // FSM state register
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FSM next-state and write/stream control decode
    always_comb begin
        nextState   = state;
        commitPend  = 1'b0;
        directWr    = 1'b0;
        deferWr     = 1'b0;
        overrunSet  = 1'b0;
        overlapSet  = 1'b0;
        startStream = 1'b0;
        lastRead    = 1'b0;
        case (state)
            IDLE: begin
                // A held sample commits first; a coincident new sample re-fills pending
                commitPend = pendValid;
                directWr   = wrEdge & ~pendValid;
                deferWr    = wrEdge & pendValid;
                if (fltEdge) begin
                    startStream = 1'b1;
                    nextState   = STREAM;
                end
            end
            STREAM: begin
                deferWr    = wrEdge;
                overrunSet = wrEdge & pendValid;
                overlapSet = fltEdge;
                if (tapK == LAST_K) begin
                    lastRead  = 1'b1;
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Sample storage; contents are deliberately not reset
    always_ff @(posedge Clk_100M) begin
        if (doWrite) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Pending sample payload
    always_ff @(posedge Clk_100M) begin
        if (deferWr) begin
            pendData <= SampleIn;
        end
    end

    // Pending-valid flag
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            pendValid <= 1'b0;
        end else if (deferWr) begin
            pendValid <= 1'b1;
        end else if (commitPend) begin
            pendValid <= 1'b0;
        end
    end

    // Write pointer and saturating fill count
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            wrPtr   <= '0;
            fillCnt <= '0;
        end else if (doWrite) begin
            wrPtr   <= wrPtr + ADDR_W'(1);
            fillCnt <= fillNext;
        end
    end

    // Stream snapshot and tap counter; a same-cycle write is part of the snapshot
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            tapK     <= '0;
            baseAddr <= '0;
            fillSnap <= '0;
            Busy     <= 1'b0;
        end else if (startStream) begin
            baseAddr <= doWrite ? wrPtr : wrPtr - ADDR_W'(1);
            fillSnap <= doWrite ? fillNext : fillCnt;
            tapK     <= '0;
            Busy     <= 1'b1;
        end else if (state == STREAM) begin
            tapK <= tapK + ADDR_W'(1);
            if (lastRead) begin
                Busy <= 1'b0;
            end
        end
    end

    // Registered tap output stage, one cycle behind the read issue
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            TapData  <= '0;
            TapIndex <= '0;
            TapValid <= 1'b0;
            TapFirst <= 1'b0;
            TapLast  <= 1'b0;
        end else if (state == STREAM) begin
            TapData  <= readHit ? mem[readAddr] : '0;
            TapIndex <= tapK;
            TapValid <= 1'b1;
            TapFirst <= (tapK == '0);
            TapLast  <= lastRead;
        end else begin
            TapData  <= '0;
            TapIndex <= '0;
            TapValid <= 1'b0;
            TapFirst <= 1'b0;
            TapLast  <= 1'b0;
        end
    end

    // Sticky fault flags
    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            WrOverrun   <= 1'b0;
            FiltOverlap <= 1'b0;
        end else begin
            if (overrunSet) begin
                WrOverrun <= 1'b1;
            end
            if (overlapSet) begin
                FiltOverlap <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_anc_tap_buffer.sv
// Testbench for anc_tap_buffer: a list model of written samples predicts each
// stream; expected taps are queued when FilterEN rises and popped by a monitor.
module tb_anc_tap_buffer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned TAPS   = 64;
    localparam int unsigned ADDR_W = 6;

    logic              Clk_100M = 1'b0;
    logic              Reset    = 1'b1;
    logic              RAMDataEN = 1'b0;
    logic [DATA_W-1:0] SampleIn = '0;
    logic              FilterEN = 1'b0;
    logic [DATA_W-1:0] TapData;
    logic [ADDR_W-1:0] TapIndex;
    logic              TapValid;
    logic              TapFirst;
    logic              TapLast;
    logic              Busy;
    logic              WrOverrun;
    logic              FiltOverlap;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] idx;
    } tapExp_t;

    tapExp_t           expQ[$];
    logic [DATA_W-1:0] model[$];
    int                nCompared   = 0;
    int                nMismatched = 0;
    int                validCnt    = 0;
    tapExp_t           monExp;
    logic              monFirst;
    logic              monLast;
    logic              monBusy;

    anc_tap_buffer #(
        .DATA_W(DATA_W),
        .TAPS  (TAPS),
        .ADDR_W(ADDR_W)
    ) dut (
        .Clk_100M   (Clk_100M),
        .Reset      (Reset),
        .RAMDataEN  (RAMDataEN),
        .SampleIn   (SampleIn),
        .FilterEN   (FilterEN),
        .TapData    (TapData),
        .TapIndex   (TapIndex),
        .TapValid   (TapValid),
        .TapFirst   (TapFirst),
        .TapLast    (TapLast),
        .Busy       (Busy),
        .WrOverrun  (WrOverrun),
        .FiltOverlap(FiltOverlap)
    );

    always #5 Clk_100M = ~Clk_100M;

    // Scoreboard monitor: every valid tap must match the head of the queue
    always @(negedge Clk_100M) begin
        if (TapValid) begin
            validCnt++;
            nCompared++;
            if (expQ.size() == 0) begin
                nMismatched++;
                $display("FAIL unexpected_tap: got idx=%0d data=%h, want no valid tap", TapIndex, TapData);
            end else begin
                monExp   = expQ.pop_front();
                monFirst = (monExp.idx == ADDR_W'(0));
                monLast  = (monExp.idx == ADDR_W'(TAPS - 1));
                monBusy  = ~monLast;
                if ({TapData, TapIndex, TapFirst, TapLast, Busy} !==
                    {monExp.data, monExp.idx, monFirst, monLast, monBusy}) begin
                    nMismatched++;
                    $display("FAIL tap_k%0d: got data=%h idx=%0d first=%b last=%b busy=%b, want data=%h idx=%0d first=%b last=%b busy=%b",
                             monExp.idx, TapData, TapIndex, TapFirst, TapLast, Busy,
                             monExp.data, monExp.idx, monFirst, monLast, monBusy);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk_100M);
    endtask

    task automatic do_reset();
        @(negedge Clk_100M);
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
        model.delete();
        expQ.delete();
        tick(1);
    endtask

    task automatic write_pulse(input logic [DATA_W-1:0] v);
        @(negedge Clk_100M);
        SampleIn  = v;
        RAMDataEN = 1'b1;
        @(negedge Clk_100M);
        RAMDataEN = 1'b0;
    endtask

    task automatic write_sample(input logic [DATA_W-1:0] v);
        write_pulse(v);
        model.push_back(v);
    endtask

    // Queue the newest-first snapshot of the model, zero beyond its length
    task automatic push_stream();
        tapExp_t e;
        validCnt = 0;
        for (int k = 0; k < int'(TAPS); k++) begin
            e.data = (k < model.size()) ? model[model.size() - 1 - k] : DATA_W'(0);
            e.idx  = ADDR_W'(k);
            expQ.push_back(e);
        end
    endtask

    // Raise FilterEN for one cycle with the expected snapshot queued
    task automatic start_stream();
        @(negedge Clk_100M);
        FilterEN = 1'b1;
        push_stream();
        @(negedge Clk_100M);
        FilterEN = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((expQ.size() != 0 || TapValid) && t < 300) begin
            @(negedge Clk_100M);
            t++;
        end
        if (t >= 300) begin
            nCompared++;
            nMismatched++;
            $display("FAIL %s_drain: got %0d taps still pending, want 0", name, expQ.size());
            expQ.delete();
        end
        tick(2);
    endtask

    task automatic run_stream(input string name);
        start_stream();
        wait_drain(name);
        nCompared++;
        if (validCnt !== int'(TAPS)) begin
            nMismatched++;
            $display("FAIL %s_count: got %0d valid cycles, want %0d", name, validCnt, TAPS);
        end
    endtask

    task automatic test_reset();
        RAMDataEN = 1'b0;
        FilterEN  = 1'b0;
        do_reset();
        nCompared++;
        if ({TapData, TapIndex, TapValid, TapFirst, TapLast, Busy, WrOverrun, FiltOverlap} !== '0) begin
            nMismatched++;
            $display("FAIL reset_outputs: got data=%h idx=%0d v=%b f=%b l=%b busy=%b ovr=%b ovl=%b, want all 0",
                     TapData, TapIndex, TapValid, TapFirst, TapLast, Busy, WrOverrun, FiltOverlap);
        end
    endtask

    task automatic test_fill_wrap();
        for (int i = 1; i <= 70; i++) write_sample(DATA_W'(i));
        start_stream();
        nCompared++;
        if (TapValid !== 1'b0 || Busy !== 1'b1) begin
            nMismatched++;
            $display("FAIL latency_cycle1: got valid=%b busy=%b, want valid=0 busy=1", TapValid, Busy);
        end
        @(negedge Clk_100M);
        nCompared++;
        if (TapValid !== 1'b1 || TapFirst !== 1'b1) begin
            nMismatched++;
            $display("FAIL latency_cycle2: got valid=%b first=%b, want valid=1 first=1", TapValid, TapFirst);
        end
        wait_drain("fill_wrap");
        nCompared++;
        if (validCnt !== int'(TAPS)) begin
            nMismatched++;
            $display("FAIL fill_wrap_count: got %0d valid cycles, want %0d", validCnt, TAPS);
        end
    endtask

    task automatic test_partial();
        do_reset();
        write_sample(16'h0011);
        write_sample(16'h0022);
        write_sample(16'h0033);
        run_stream("partial");
    endtask

    task automatic test_defer_single();
        start_stream();
        tick(10);
        write_pulse(16'h7FFF);
        wait_drain("defer_stream");
        model.push_back(16'h7FFF);
        nCompared++;
        if (WrOverrun !== 1'b0) begin
            nMismatched++;
            $display("FAIL defer_overrun: got WrOverrun=%b, want 0", WrOverrun);
        end
        run_stream("defer_next");
    endtask

    task automatic test_overrun();
        start_stream();
        tick(5);
        write_pulse(16'h1234);
        tick(3);
        write_pulse(16'h5678);
        wait_drain("overrun_stream");
        model.push_back(16'h5678);
        nCompared++;
        if (WrOverrun !== 1'b1) begin
            nMismatched++;
            $display("FAIL overrun_flag: got WrOverrun=%b, want 1", WrOverrun);
        end
        run_stream("overrun_next");
    endtask

    task automatic test_overlap();
        int bad = 0;
        start_stream();
        tick(5);
        FilterEN = 1'b1;
        @(negedge Clk_100M);
        FilterEN = 1'b0;
        wait_drain("overlap");
        nCompared++;
        if (FiltOverlap !== 1'b1 || validCnt !== int'(TAPS)) begin
            nMismatched++;
            $display("FAIL overlap_flag: got FiltOverlap=%b count=%0d, want 1 and %0d", FiltOverlap, validCnt, TAPS);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk_100M);
            if (TapValid !== 1'b0 || Busy !== 1'b0) bad++;
        end
        nCompared++;
        if (bad != 0) begin
            nMismatched++;
            $display("FAIL overlap_restart: got %0d active cycles after stream, want 0", bad);
        end
    endtask

    task automatic test_reset_abort();
        start_stream();
        tick(20);
        Reset = 1'b1;
        @(negedge Clk_100M);
        nCompared++;
        if (TapValid !== 1'b0 || Busy !== 1'b0) begin
            nMismatched++;
            $display("FAIL abort_outputs: got valid=%b busy=%b, want 0 0", TapValid, Busy);
        end
        Reset = 1'b0;
        expQ.delete();
        model.delete();
        tick(1);
        nCompared++;
        if (WrOverrun !== 1'b0 || FiltOverlap !== 1'b0) begin
            nMismatched++;
            $display("FAIL abort_sticky: got ovr=%b ovl=%b, want 0 0", WrOverrun, FiltOverlap);
        end
        run_stream("abort_zeros");
    endtask

    task automatic test_held_high();
        int bad = 0;
        @(negedge Clk_100M);
        Reset     = 1'b1;
        RAMDataEN = 1'b1;
        FilterEN  = 1'b1;
        SampleIn  = 16'hBEEF;
        tick(2);
        Reset = 1'b0;
        model.delete();
        expQ.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk_100M);
            if (TapValid !== 1'b0 || Busy !== 1'b0) bad++;
        end
        nCompared++;
        if (bad != 0) begin
            nMismatched++;
            $display("FAIL held_no_stream: got %0d active cycles, want 0", bad);
        end
        RAMDataEN = 1'b0;
        FilterEN  = 1'b0;
        tick(1);
        run_stream("held_no_write");
        write_sample(16'h0ABC);
        run_stream("held_rearm");
    endtask

    initial begin
        test_reset();
        test_fill_wrap();
        test_partial();
        test_defer_single();
        test_overrun();
        test_overlap();
        test_reset_abort();
        test_held_high();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
